// File: rtl/disc_pkg.sv
// Shared constants, loader state encoding and the pixel-to-Q8.8 normaliser
// for the discriminator front end.
`timescale 1ns/1ps
package disc_pkg;

    localparam int N_PIX     = 256;
    localparam int PIX_W     = 8;
    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int CNT_W     = $clog2(N_PIX);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } loader_state_e;

    // (pix - 128) / 128 in Q8.8 is (pix - 128) << (FRAC_BITS - PIX_W + 1).
    localparam int Q_SHIFT = FRAC_BITS - PIX_W + 1;

    function automatic logic [DATA_W-1:0] pix_to_q88(input logic [PIX_W-1:0] pix);
        logic        [PIX_W:0]    w_diff;
        logic signed [DATA_W-1:0] w_ext;
        w_diff = {1'b0, pix} - (PIX_W+1)'(1 << (PIX_W-1));
        w_ext  = DATA_W'($signed(w_diff));
        return w_ext <<< Q_SHIFT;
    endfunction

endpackage

// File: rtl/disc_frame_loader_if.sv
// Bundle of the pixel stream, discriminator link and result stream seen by
// the frame loader.
`timescale 1ns/1ps
interface disc_frame_loader_if #(
    parameter int N_PIX  = 256,
    parameter int PIX_W  = 8,
    parameter int DATA_W = 16
);
    // Both streams (in_*, res_*) transfer on a cycle where valid && ready;
    // the source holds data stable while valid is high and ready is low.
    logic                    in_valid;
    logic                    in_ready;
    logic [PIX_W-1:0]        in_data;
    logic                    in_last;

    logic [DATA_W*N_PIX-1:0] flat_input;
    logic                    disc_start;
    logic                    disc_done;
    logic [DATA_W-1:0]       disc_score;
    logic                    disc_real;

    logic                    res_valid;
    logic                    res_ready;
    logic [DATA_W-1:0]       res_score;
    logic                    res_real;
    logic                    frame_err;

    modport master (
        output in_valid, in_data, in_last, disc_done, disc_score, disc_real, res_ready,
        input  in_ready, flat_input, disc_start, res_valid, res_score, res_real, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_last, disc_done, disc_score, disc_real, res_ready,
        output in_ready, flat_input, disc_start, res_valid, res_score, res_real, frame_err
    );

endinterface

// File: rtl/disc_frame_buffer.sv
// N_PIX x DATA_W sample register file exposed as one flattened bus;
// slot k lives at bits [DATA_W*k +: DATA_W].
`timescale 1ns/1ps
module disc_frame_buffer
    import disc_pkg::*;
#(
    parameter int DEPTH = N_PIX,
    parameter int WIDTH = DATA_W,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_we,
    input  logic [IDX_W-1:0]       i_idx,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH*DEPTH-1:0] o_flat
);

    logic [WIDTH*DEPTH-1:0] r_flat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flat <= '0;
        end else if (i_we) begin
            r_flat[i_idx*WIDTH +: WIDTH] <= i_wdata;
        end
    end

    assign o_flat = r_flat;

endmodule

// File: rtl/disc_frame_loader.sv
// Fills the discriminator input buffer from a pixel stream, launches one run
// per complete frame and hands the captured score back on a result stream.
`timescale 1ns/1ps
module disc_frame_loader
    import disc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    disc_frame_loader_if.slave  bus,
    output loader_state_e       o_state
);

    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_frame_err;
    logic [DATA_W-1:0] r_res_score;
    logic              r_res_real;

    logic              w_accept;
    logic              w_at_end;
    logic              w_frame_bad;
    logic              w_we;
    logic [DATA_W-1:0] w_sample;

    assign w_accept    = bus.in_valid && (r_state == S_FILL);
    assign w_at_end    = (r_cnt == CNT_W'(N_PIX-1));
    // A frame is well formed only when in_last coincides with the final slot.
    assign w_frame_bad = w_accept && (bus.in_last != w_at_end);
    assign w_we        = w_accept && !w_frame_bad;
    assign w_sample    = pix_to_q88(bus.in_data);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    if (w_frame_bad) begin
                        w_cnt_nxt = '0;
                    end else if (w_at_end) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_LAUNCH;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.disc_done) w_state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (bus.res_ready) begin
                    w_state_nxt = S_FILL;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
            r_res_score <= '0;
            r_res_real  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_frame_err <= w_frame_bad;
            if (r_state == S_WAIT && bus.disc_done) begin
                r_res_score <= bus.disc_score;
                r_res_real  <= bus.disc_real;
            end
        end
    end

    disc_frame_buffer #(
        .DEPTH (N_PIX),
        .WIDTH (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_idx   (r_cnt),
        .i_wdata (w_sample),
        .o_flat  (bus.flat_input)
    );

    // Handshake outputs decode straight from the state register.
    assign bus.in_ready   = (r_state == S_FILL);
    assign bus.disc_start = (r_state == S_LAUNCH);
    assign bus.res_valid  = (r_state == S_RESULT);
    assign bus.res_score  = r_res_score;
    assign bus.res_real   = r_res_real;
    assign bus.frame_err  = r_frame_err;
    assign o_state        = loader_state_e'(r_state);

endmodule
